// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, default sizing
// and the round-robin pointer helper.
package uart_tx_arbiter_pkg;

    localparam int DEF_NUM_REQ      = 3;
    localparam int DEF_LOCK_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_LOCKED = 3'd4
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr_i,
// wrapping, as a one-hot grant plus its index.
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NUM_REQ);

    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default first, so no path leaves a latch.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_i} + (IDW + 1)'(k);
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            cand = sum[IDW-1:0];
            if (!any_o && req_valid_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock in front of a single UART TX byte
// interface; a lock ends on a last=1 byte or after LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 uart_tx_data,
    output logic                       uart_tx_valid,
    input  logic                       uart_tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       lock_timeout
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(LOCK_TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LOCK_TIMEOUT - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [7:0]     data_q, data_d;
    logic           locked_q, locked_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [IDW-1:0]     sel_idx;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               idle_hs, lock_hs;

    uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .idx_o       (pick_idx),
        .any_o       (pick_any)
    );

    assign idle_hs = (state_q == ST_IDLE)   && !uart_tx_busy && pick_any;
    assign lock_hs = (state_q == ST_LOCKED) && !uart_tx_busy && req_valid[grant_q];
    assign sel_idx = (state_q == ST_LOCKED) ? grant_q : pick_idx;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDW'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset sampled on the edge; all state updates are non-blocking.
        if (!resetn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (idle_hs) begin
                    state_d  = ST_LAUNCH;
                    data_d   = sel_data;
                    grant_d  = pick_idx;
                    rr_ptr_d = IDW'(rr_next(int'(pick_idx), NUM_REQ));
                    locked_d = !sel_last;
                end
            end
            ST_LAUNCH: state_d = ST_SETTLE;
            // The TX core may not raise busy until the cycle after launch.
            ST_SETTLE: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!uart_tx_busy) begin
                    cnt_d   = '0;
                    state_d = locked_q ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (lock_hs) begin
                    state_d  = ST_LAUNCH;
                    data_d   = sel_data;
                    locked_d = !sel_last;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        uart_tx_valid = 1'b0;
        lock_timeout  = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (!uart_tx_busy) req_ready = pick_grant;
            ST_LAUNCH: uart_tx_valid = 1'b1;
            ST_LOCKED: begin
                if (lock_hs) req_ready = NUM_REQ'(1) << grant_q;
                lock_timeout = !lock_hs && (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    assign uart_tx_data = data_q;
    assign grant_id     = grant_q;
    assign locked       = locked_q;

endmodule
